// File: rtl/dec_mpp_qres_unpack.sv
// Decoder-side MPP residual unpacker: pulls fixed-width fields from four
// substream bit buffers, sign-extends them and presents 16-entry arrays per block.
module dec_mpp_qres_unpack #(
  parameter int NSS = 4,
  parameter int WW  = 32,
  parameter int BPC = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          slice_clr,
  input  logic          start,
  input  logic [3:0]    bits_c0,
  input  logic [3:0]    bits_c1,
  input  logic [3:0]    bits_c2,
  input  logic [WW-1:0] ss_data [0:NSS-1],
  input  logic          ss_vld  [0:NSS-1],
  output logic          ss_rdy  [0:NSS-1],
  output logic          busy,
  output logic          blk_vld,
  output logic [7:0]    mpp_qres_ssm0 [0:15],
  output logic [7:0]    mpp_qres_ssm1 [0:15],
  output logic [7:0]    mpp_qres_ssm2 [0:15],
  output logic [7:0]    mpp_qres_ssm3 [0:15]
);

  localparam int              BW        = 2 * WW;
  localparam int              CW        = $clog2(BW + 1);
  localparam logic [CW-1:0]   WORD_BITS = CW'(WW);
  localparam logic [3:0]      WMAX      = (BPC < 8) ? 4'(BPC) : 4'd8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] buf_q [NSS], buf_d [NSS], buf_ld [NSS];
  logic [CW-1:0] cnt_q [NSS], cnt_d [NSS], cnt_ld [NSS];
  logic [4:0]    idx_q [NSS], idx_d [NSS];
  // Entry 3 stays zero: it is the width of ssm0 fields 12..15.
  logic [3:0]    w_q [4], w_d [4];
  logic [7:0]    res_q [NSS][16], res_d [NSS][16];
  logic [3:0]    fw [NSS];
  logic          load [NSS], take [NSS];
  logic          all_done;

  function automatic logic [7:0] sext_field(input logic [BW-1:0] b, input logic [3:0] w);
    if (w == 4'd0) return 8'h00;
    return 8'($signed(b[BW-1 -: 8]) >>> (4'd8 - w));
  endfunction

  function automatic logic [3:0] clamp_w(input logic [3:0] b);
    return (b > WMAX) ? WMAX : b;
  endfunction

  always_comb begin
    for (int k = 0; k < NSS; k++)
      ss_rdy[k] = rstn && !slice_clr && (cnt_q[k] <= WORD_BITS);
  end

  always_comb begin
    // NOTE: every _d starts from its _q, so no branch can leave a latch behind.
    state_d  = state_q;
    w_d      = w_q;
    res_d    = res_q;
    all_done = 1'b1;
    for (int k = 0; k < NSS; k++) begin
      load[k]   = ss_vld[k] && ss_rdy[k];
      // A word arriving this cycle is usable at once, so an empty buffer need not stall.
      buf_ld[k] = load[k] ? (buf_q[k] | ({ss_data[k], {WW{1'b0}}} >> cnt_q[k])) : buf_q[k];
      cnt_ld[k] = load[k] ? cnt_q[k] + WORD_BITS : cnt_q[k];
      if (k == 0) fw[k] = w_q[idx_q[k][3:2]];
      else        fw[k] = w_q[(k - 1) & 3];
      take[k]  = (state_q == RUN) && !slice_clr && !idx_q[k][4] && (cnt_ld[k] >= CW'(fw[k]));
      buf_d[k] = take[k] ? buf_ld[k] << fw[k] : buf_ld[k];
      cnt_d[k] = take[k] ? cnt_ld[k] - CW'(fw[k]) : cnt_ld[k];
      idx_d[k] = take[k] ? idx_q[k] + 5'd1 : idx_q[k];
      if (take[k]) res_d[k][idx_q[k][3:0]] = sext_field(buf_ld[k], fw[k]);
      if (idx_d[k] != 5'd16) all_done = 1'b0;
    end

    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        w_d[0]  = clamp_w(bits_c0);
        w_d[1]  = clamp_w(bits_c1);
        w_d[2]  = clamp_w(bits_c2);
        for (int k = 0; k < NSS; k++) idx_d[k] = '0;
      end
      RUN:     if (all_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (slice_clr) begin
      state_d = IDLE;
      for (int k = 0; k < NSS; k++) begin
        buf_d[k] = '0;
        cnt_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (!rstn) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) w_q[i] <= '0;
      for (int k = 0; k < NSS; k++) begin
        buf_q[k] <= '0;
        cnt_q[k] <= '0;
        idx_q[k] <= '0;
        // NOTE: the residual array is reset too, since downstream must read 00 after reset.
        for (int j = 0; j < 16; j++) res_q[k][j] <= '0;
      end
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign blk_vld       = (state_q == DONE);
  assign mpp_qres_ssm0 = res_q[0];
  assign mpp_qres_ssm1 = res_q[1];
  assign mpp_qres_ssm2 = res_q[2];
  assign mpp_qres_ssm3 = res_q[3];

endmodule
